// File: rtl/mem_line_arbiter_if.sv
// Bundle of the two cache-side request ports, the main_mem port and the owner indicator.
// slave is the arbiter side; master is the cache/memory side that drives the requests.
interface mem_line_arbiter_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9
);
  localparam int LW = 32 << LINE_ADDR_LEN;

  logic                p0_rd_req;
  logic                p0_wr_req;
  logic [ADDR_LEN-1:0] p0_addr;
  logic [LW-1:0]       p0_wr_line;
  logic                p0_gnt;
  logic [LW-1:0]       p0_rd_line;

  logic                p1_rd_req;
  logic                p1_wr_req;
  logic [ADDR_LEN-1:0] p1_addr;
  logic [LW-1:0]       p1_wr_line;
  logic                p1_gnt;
  logic [LW-1:0]       p1_rd_line;

  logic                mem_rd_req;
  logic                mem_wr_req;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [LW-1:0]       mem_wr_line;
  logic [LW-1:0]       mem_rd_line;
  logic                mem_gnt;

  logic                owner;

  modport slave (
    input  p0_rd_req, p0_wr_req, p0_addr, p0_wr_line,
    output p0_gnt, p0_rd_line,
    input  p1_rd_req, p1_wr_req, p1_addr, p1_wr_line,
    output p1_gnt, p1_rd_line,
    output mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
    input  mem_rd_line, mem_gnt,
    output owner
  );

  modport master (
    output p0_rd_req, p0_wr_req, p0_addr, p0_wr_line,
    input  p0_gnt, p0_rd_line,
    output p1_rd_req, p1_wr_req, p1_addr, p1_wr_line,
    input  p1_gnt, p1_rd_line,
    input  mem_rd_req, mem_wr_req, mem_addr, mem_wr_line,
    output mem_rd_line, mem_gnt,
    input  owner
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Two-port line arbiter (port 0 D-cache, port 1 I-cache) in front of a single main_mem.
// Tie-break: MEM_ARB_RR_EN defined selects round-robin, otherwise port 0 has fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; a winner's command is latched on leaving
// BUSY  | latched command presented to main_mem until mem_gnt
// GAP   | one-cycle gnt pulse to the owner, requests ignored
module mem_line_arbiter #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9
) (
  input logic               clk,
  input logic               rst,
  mem_line_arbiter_if.slave bus
);
  localparam int LW = 32 << LINE_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t              state_q, state_d;
  logic                last_q;
  logic                owner_q;
  logic                is_wr_q;
  logic [ADDR_LEN-1:0] mem_addr_q;
  logic [LW-1:0]       mem_wr_line_q;
  logic [LW-1:0]       rd_line0_q, rd_line1_q;

  logic p0_req, p1_req, tie_win;
  logic take, win;
  logic win_wr;

  assign p0_req = bus.p0_rd_req | bus.p0_wr_req;
  assign p1_req = bus.p1_rd_req | bus.p1_wr_req;
  assign win_wr = win ? bus.p1_wr_req : bus.p0_wr_req;

`ifdef MEM_ARB_RR_EN
  assign tie_win = ~last_q;
`else
  // last is kept up to date so both builds share the same state; it only steers ties in round-robin
  logic unused_last;
  assign tie_win     = 1'b0;
  assign unused_last = last_q;
`endif

  always_comb begin
    state_d        = state_q;
    take           = 1'b0;
    win            = 1'b0;
    bus.mem_rd_req = 1'b0;
    bus.mem_wr_req = 1'b0;
    bus.p0_gnt     = 1'b0;
    bus.p1_gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          take    = 1'b1;
          win     = (p0_req && p1_req) ? tie_win : p1_req;
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus.mem_wr_req = is_wr_q;
        bus.mem_rd_req = ~is_wr_q;
        if (bus.mem_gnt) state_d = GAP;
      end
      GAP: begin
        bus.p0_gnt = ~owner_q;
        bus.p1_gnt = owner_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      owner_q       <= 1'b0;
      is_wr_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_line_q <= '0;
      rd_line0_q    <= '0;
      rd_line1_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q    <= win;
        is_wr_q    <= win_wr;
        mem_addr_q <= win ? bus.p1_addr : bus.p0_addr;
        if (win_wr) mem_wr_line_q <= win ? bus.p1_wr_line : bus.p0_wr_line;
      end
      if (state_q == BUSY && bus.mem_gnt) begin
        last_q <= owner_q;
        if (!is_wr_q) begin
          if (owner_q) rd_line1_q <= bus.mem_rd_line;
          else         rd_line0_q <= bus.mem_rd_line;
        end
      end
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_line = mem_wr_line_q;
  assign bus.p0_rd_line  = rd_line0_q;
  assign bus.p1_rd_line  = rd_line1_q;
  assign bus.owner       = owner_q;
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter with a fixed-latency line memory model.
module tb_mem_line_arbiter;
  localparam int LAL = 3;
  localparam int AL  = 9;
  localparam int LW  = 32 << LAL;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  mem_line_arbiter_if #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) bus ();
  mem_line_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] init_line(input int a);
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = 32'h1000_0000 + (a << 8) + i;
    return l;
  endfunction

  // memory model: gnt in the LAT-th cycle a request is seen
  logic [LW-1:0] mem [0:(1<<AL)-1];
  int lat_cnt = 0;
  bit mem_init = 1'b0;
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < (1 << AL); a++) mem[a] = init_line(a);
      mem_init = 1'b1;
    end
    if (rst || !(bus.mem_rd_req || bus.mem_wr_req)) begin
      lat_cnt     = 0;
      bus.mem_gnt = 1'b0;
    end else begin
      lat_cnt++;
      if (lat_cnt == LAT) begin
        if (bus.mem_wr_req) mem[bus.mem_addr] = bus.mem_wr_line;
        bus.mem_rd_line = mem[bus.mem_addr];
        bus.mem_gnt     = 1'b1;
        lat_cnt         = 0;
      end else begin
        bus.mem_gnt = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.p0_rd_req = 1'b0; bus.p0_wr_req = 1'b0;
    bus.p1_rd_req = 1'b0; bus.p1_wr_req = 1'b0;
  endtask

  task automatic xfer(input int port, input logic rd, input logic wr, input logic [AL-1:0] addr,
                      input logic [LW-1:0] line, output logic ok, output logic overlap,
                      output logic wrong_gnt);
    ok = 1'b0; overlap = 1'b0; wrong_gnt = 1'b0;
    if (port == 0) begin
      bus.p0_rd_req = rd; bus.p0_wr_req = wr; bus.p0_addr = addr; bus.p0_wr_line = line;
    end else begin
      bus.p1_rd_req = rd; bus.p1_wr_req = wr; bus.p1_addr = addr; bus.p1_wr_line = line;
    end
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      if (bus.mem_rd_req && bus.mem_wr_req) overlap = 1'b1;
      if (port == 0 ? bus.p1_gnt : bus.p0_gnt) wrong_gnt = 1'b1;
      if (port == 0 ? bus.p0_gnt : bus.p1_gnt) ok = 1'b1;
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.mem_rd_req, bus.mem_wr_req, bus.p0_gnt, bus.p1_gnt, bus.owner} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000",
               {bus.mem_rd_req, bus.mem_wr_req, bus.p0_gnt, bus.p1_gnt, bus.owner});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wr_line !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus got addr %h line %h want 0", bus.mem_addr, bus.mem_wr_line);
    end
    checks++;
    if (bus.p0_rd_line !== '0 || bus.p1_rd_line !== '0) begin
      errors++;
      $display("FAIL reset_rd_lines got %h / %h want 0", bus.p0_rd_line, bus.p1_rd_line);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    // this cycle is N: request becomes visible in IDLE
    bus.p1_rd_req = 1'b1;
    bus.p1_addr   = 9'h005;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++;
      if (bus.mem_rd_req !== 1'b1 || bus.mem_wr_req !== 1'b0 || bus.mem_addr !== 9'h005 ||
          bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin
        errors++;
        $display("FAIL single_busy cyc %0d got rd %b wr %b addr %h g0 %b g1 %b want 1 0 005 0 0",
                 k, bus.mem_rd_req, bus.mem_wr_req, bus.mem_addr, bus.p0_gnt, bus.p1_gnt);
      end
    end
    tick();
    checks++;
    if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0 || bus.mem_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL single_gnt got g1 %b g0 %b rd %b want 1 0 0", bus.p1_gnt, bus.p0_gnt, bus.mem_rd_req);
    end
    checks++;
    if (bus.p1_rd_line !== init_line(5)) begin
      errors++;
      $display("FAIL single_line got %h want %h", bus.p1_rd_line, init_line(5));
    end
    clear_reqs();
    tick();
    checks++;
    if (bus.p1_gnt !== 1'b0 || bus.p1_rd_line !== init_line(5)) begin
      errors++;
      $display("FAIL single_after got g1 %b line %h want 0 %h", bus.p1_gnt, bus.p1_rd_line, init_line(5));
    end
  endtask

  task automatic test_write_read();
    logic [LW-1:0] pat;
    logic ok, ov, wg;
    for (int i = 0; i < LW / 32; i++) pat[i*32 +: 32] = 32'hA5A5_0000 + i;
    xfer(0, 1'b0, 1'b1, 9'h01F, pat, ok, ov, wg);
    checks++;
    if (ok !== 1'b1 || ov !== 1'b0 || wg !== 1'b0) begin
      errors++;
      $display("FAIL wr_xfer got gnt %b overlap %b p1gnt %b want 1 0 0", ok, ov, wg);
    end
    xfer(0, 1'b1, 1'b0, 9'h01F, '0, ok, ov, wg);
    checks++;
    if (ok !== 1'b1 || ov !== 1'b0 || wg !== 1'b0) begin
      errors++;
      $display("FAIL rd_xfer got gnt %b overlap %b p1gnt %b want 1 0 0", ok, ov, wg);
    end
    checks++;
    if (bus.p0_rd_line !== pat) begin
      errors++;
      $display("FAIL readback got %h want %h", bus.p0_rd_line, pat);
    end
    checks++;
    if (bus.p1_rd_line !== init_line(5)) begin
      errors++;
      $display("FAIL p1_line_kept got %h want %h", bus.p1_rd_line, init_line(5));
    end
  endtask

  task automatic test_both_lines();
    logic [LW-1:0] l;
    logic ok, ov, wg;
    l = {8{32'hC0DE_0000}} ^ init_line(3);
    bus.p1_rd_req = 1'b1; bus.p1_wr_req = 1'b1; bus.p1_addr = 9'h020; bus.p1_wr_line = l;
    tick();
    checks++;
    if ({bus.mem_wr_req, bus.mem_rd_req} !== 2'b10 || bus.mem_addr !== 9'h020 ||
        bus.mem_wr_line !== l || bus.owner !== 1'b1) begin
      errors++;
      $display("FAIL both_cmd got wr %b rd %b addr %h owner %b want 1 0 020 1",
               bus.mem_wr_req, bus.mem_rd_req, bus.mem_addr, bus.owner);
    end
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      if (bus.p1_gnt) ok = 1'b1;
    end
    clear_reqs();
    tick();
    checks++;
    if (ok !== 1'b1 || bus.p1_rd_line !== init_line(5)) begin
      errors++;
      $display("FAIL both_line got gnt %b line %h want 1 %h", ok, bus.p1_rd_line, init_line(5));
    end
    xfer(0, 1'b1, 1'b0, 9'h020, '0, ok, ov, wg);
    checks++;
    if (ok !== 1'b1 || bus.p0_rd_line !== l) begin
      errors++;
      $display("FAIL both_written got gnt %b line %h want 1 %h", ok, bus.p0_rd_line, l);
    end
  endtask

  task automatic test_tie();
    int seq [4];
    int expv [4];
    int n;
    logic got1, bad0;
`ifdef MEM_ARB_RR_EN
    expv = '{0, 1, 0, 1};
`else
    expv = '{0, 0, 0, 0};
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.p0_rd_req = 1'b1; bus.p0_addr = 9'h040;
    bus.p1_rd_req = 1'b1; bus.p1_addr = 9'h041;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      tick();
      if (bus.p0_gnt) begin seq[n] = 0; n++; end
      else if (bus.p1_gnt) begin seq[n] = 1; n++; end
    end
    bus.p0_rd_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL tie_count got %0d grants want 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq[i] != expv[i]) begin
        errors++;
        $display("FAIL tie_order grant %0d got port %0d want port %0d", i, seq[i], expv[i]);
      end
    end
    got1 = 1'b0; bad0 = 1'b0;
    for (int c = 0; c < 40 && !got1; c++) begin
      tick();
      if (bus.p0_gnt) bad0 = 1'b1;
      if (bus.p1_gnt) got1 = 1'b1;
    end
    checks++;
    if (got1 !== 1'b1 || bad0 !== 1'b0 || bus.p1_rd_line !== init_line(9'h041)) begin
      errors++;
      $display("FAIL tie_p1_after_drop got g1 %b g0 %b line %h want 1 0 %h",
               got1, bad0, bus.p1_rd_line, init_line(9'h041));
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_churn_reset();
    bus.p0_rd_req = 1'b1; bus.p0_addr = 9'h010;
    tick();
    checks++;
    if (bus.mem_addr !== 9'h010 || bus.mem_rd_req !== 1'b1) begin
      errors++;
      $display("FAIL churn_start got addr %h rd %b want 010 1", bus.mem_addr, bus.mem_rd_req);
    end
    bus.p0_addr = 9'h011;
    tick();
    checks++;
    if (bus.mem_addr !== 9'h010) begin
      errors++;
      $display("FAIL churn_hold got addr %h want 010", bus.mem_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.mem_rd_req, bus.mem_wr_req, bus.p0_gnt, bus.p1_gnt, bus.owner} !== 5'b0 ||
        bus.mem_addr !== '0 || bus.p0_rd_line !== '0 || bus.p1_rd_line !== '0) begin
      errors++;
      $display("FAIL busy_reset got ctrl %b addr %h want 00000 000",
               {bus.mem_rd_req, bus.mem_wr_req, bus.p0_gnt, bus.p1_gnt, bus.owner}, bus.mem_addr);
    end
    rst = 1'b0;
    clear_reqs();
    tick();
    checks++;
    if ({bus.mem_rd_req, bus.mem_wr_req, bus.p0_gnt, bus.p1_gnt} !== 4'b0) begin
      errors++;
      $display("FAIL post_reset got %b want 0000",
               {bus.mem_rd_req, bus.mem_wr_req, bus.p0_gnt, bus.p1_gnt});
    end
  endtask

  initial begin
    clear_reqs();
    bus.p0_addr = '0; bus.p0_wr_line = '0;
    bus.p1_addr = '0; bus.p1_wr_line = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_both_lines();
    test_tie();
    test_churn_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
